// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR fault monitor: register word offsets,
// recovery FSM encoding, AXI response code and small bit-level helpers.
package tmr_pkg;

    // Register word index, decoded from address bits [3:2]
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CNT0   = 2'd1;
    localparam logic [1:0] REG_CNT1   = 2'd2;
    localparam logic [1:0] REG_CNT2   = 2'd3;

    // AXI OKAY response
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Per-replica recovery state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } rec_state_e;

    // Write-one-to-clear with a set input that takes priority over the clear
    function automatic logic w1c_set(input logic cur, input logic clr, input logic set);
        return (cur & ~clr) | set;
    endfunction

endpackage

// File: rtl/tmr_replica_tracker.sv
// One replica's fault bookkeeping: saturating fault counter, sticky fault
// flag and the IDLE/REQ recovery handshake with the external recovery agent.
module tmr_replica_tracker
    import tmr_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter int FAULT_THRESHOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fault,
    input  logic                 cnt_clr,
    input  logic                 sticky_clr,
    input  logic                 ack,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 sticky,
    output logic                 req
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    // Threshold held at 32 bits so a threshold beyond the counter range simply never fires
    localparam logic [31:0]          THRESH   = FAULT_THRESHOLD;

    rec_state_e             state_r;
    rec_state_e             state_s;
    logic                   exit_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cnt_s;
    logic                   sticky_r;
    logic                   sticky_s;
    logic                   req_r;
    logic [31:0]            cnt_ext_s;

    assign cnt_ext_s = 32'(cnt_r);

    // Recovery FSM next state; leaving REQ also flags the counter clear
    always_comb begin
        state_s = state_r;
        exit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cnt_ext_s >= THRESH) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_s = ST_IDLE;
                    exit_s  = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end
            default: begin
                state_s = ST_IDLE;
                exit_s  = 1'b0;
            end
        endcase
    end

    // Counter and sticky next values; any clear beats a same-cycle increment
    always_comb begin
        cnt_s    = cnt_r;
        sticky_s = w1c_set(sticky_r, sticky_clr, fault);
        if (cnt_clr || exit_s) begin
            cnt_s = CNT_ZERO;
        end else if (fault && (cnt_r != CNT_MAX)) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, counter, sticky flag and registered request output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            sticky_r <= 1'b0;
            req_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            sticky_r <= sticky_s;
            req_r    <= (state_s == ST_REQ);
        end
    end

    assign cnt    = cnt_r;
    assign sticky = sticky_r;
    assign req    = req_r;

endmodule

// File: rtl/tmr_fault_monitor.sv
// TMR fault monitor: counts voter mismatches per replica, raises a sticky
// interrupt, requests replica recovery past a threshold, and exposes
// status/counters over an AXI4-Lite subordinate port.
module tmr_fault_monitor
    import tmr_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int CNT_WIDTH          = 16,
    parameter int FAULT_THRESHOLD    = 16
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic                            fault00,
    input  logic                            fault01,
    input  logic                            fault02,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [2:0]                      recover_req,
    input  logic [2:0]                      recover_ack,
    output logic                            irq
);

    localparam logic [C_S_AXI_DATA_WIDTH-1:0] DATA_ZERO = {C_S_AXI_DATA_WIDTH{1'b0}};

    logic [2:0]                     fault_s;
    logic [2:0]                     cnt_clr_s;
    logic [2:0]                     sticky_clr_s;
    logic [2:0]                     sticky_s;
    logic [2:0]                     recover_req_s;
    logic [CNT_WIDTH-1:0]           cnt_s [3];
    logic                           wr_en_s;
    logic                           rd_en_s;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rd_data_s;

    logic                           awready_r;
    logic                           wready_r;
    logic                           bvalid_r;
    logic [1:0]                     bresp_r;
    logic                           arready_r;
    logic                           rvalid_r;
    logic [1:0]                     rresp_r;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata_r;

    // Address/data bits outside the decoded range are intentionally ignored
    logic unused_s;
    assign unused_s = ^{s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4], s00_axi_awaddr[1:0],
                        s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4], s00_axi_araddr[1:0],
                        s00_axi_wdata[C_S_AXI_DATA_WIDTH-1:3]};

    assign fault_s = {fault02, fault01, fault00};
    assign wr_en_s = awready_r & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en_s = arready_r & s00_axi_arvalid;

    // Write decode: W1C on STATUS sticky bits, any write to a counter clears it
    always_comb begin
        cnt_clr_s    = 3'b000;
        sticky_clr_s = 3'b000;
        if (wr_en_s) begin
            case (s00_axi_awaddr[3:2])
                REG_STATUS: sticky_clr_s = s00_axi_wdata[2:0];
                REG_CNT0:   cnt_clr_s    = 3'b001;
                REG_CNT1:   cnt_clr_s    = 3'b010;
                REG_CNT2:   cnt_clr_s    = 3'b100;
                default:    cnt_clr_s    = 3'b000;
            endcase
        end else begin
            cnt_clr_s    = 3'b000;
            sticky_clr_s = 3'b000;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_replica
        tmr_replica_tracker #(
            .CNT_WIDTH       (CNT_WIDTH),
            .FAULT_THRESHOLD (FAULT_THRESHOLD)
        ) u_tracker (
            .clk        (axi_aclk),
            .rst_n      (axi_resetn),
            .fault      (fault_s[gi]),
            .cnt_clr    (cnt_clr_s[gi]),
            .sticky_clr (sticky_clr_s[gi]),
            .ack        (recover_ack[gi]),
            .cnt        (cnt_s[gi]),
            .sticky     (sticky_s[gi]),
            .req        (recover_req_s[gi])
        );
    end

    // Read mux over the four registers, counters zero-extended
    always_comb begin
        rd_data_s = DATA_ZERO;
        case (s00_axi_araddr[3:2])
            REG_STATUS: rd_data_s = C_S_AXI_DATA_WIDTH'({recover_req_s, sticky_s});
            REG_CNT0:   rd_data_s = C_S_AXI_DATA_WIDTH'(cnt_s[0]);
            REG_CNT1:   rd_data_s = C_S_AXI_DATA_WIDTH'(cnt_s[1]);
            REG_CNT2:   rd_data_s = C_S_AXI_DATA_WIDTH'(cnt_s[2]);
            default:    rd_data_s = DATA_ZERO;
        endcase
    end

    // Write channel: one-cycle joint aw/w ready, then hold the response until bready
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            if (!awready_r && s00_axi_awvalid && s00_axi_wvalid && !bvalid_r) begin
                awready_r <= 1'b1;
                wready_r  <= 1'b1;
            end else begin
                awready_r <= 1'b0;
                wready_r  <= 1'b0;
            end
            if (wr_en_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= RESP_OKAY;
            end else if (bvalid_r && s00_axi_bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read channel: one-cycle arready, capture data, hold rvalid/rdata until rready
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rresp_r   <= 2'b00;
            rdata_r   <= DATA_ZERO;
        end else begin
            arready_r <= s00_axi_arvalid & ~rvalid_r & ~arready_r;
            if (rd_en_s) begin
                rvalid_r <= 1'b1;
                rresp_r  <= RESP_OKAY;
                rdata_r  <= rd_data_s;
            end else if (rvalid_r && s00_axi_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign s00_axi_awready = awready_r;
    assign s00_axi_wready  = wready_r;
    assign s00_axi_bvalid  = bvalid_r;
    assign s00_axi_bresp   = bresp_r;
    assign s00_axi_arready = arready_r;
    assign s00_axi_rvalid  = rvalid_r;
    assign s00_axi_rresp   = rresp_r;
    assign s00_axi_rdata   = rdata_r;
    assign recover_req     = recover_req_s;
    assign irq             = |sticky_s;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Bench for tmr_fault_monitor: a table of fault patterns followed by register
// reads with hand-computed results, then directed multi-cycle sequences for
// recovery, W1C/clear priority, read back-pressure, saturation and reset.
module tb_tmr_fault_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f0, f1, f2;
    logic [2:0]  f4;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [2:0]  ack;
    logic [2:0]  ack4;

    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [2:0]  recover_req;

    logic        awready4, wready4, bvalid4, arready4, rvalid4, irq4;
    logic [1:0]  bresp4, rresp4;
    logic [31:0] rdata4;
    logic [2:0]  recover_req4;
    logic [31:0] rdata4_cap;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tmr_fault_monitor dut (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .fault00(f0), .fault01(f1), .fault02(f2),
        .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .recover_req(recover_req), .recover_ack(ack), .irq(irq)
    );

    tmr_fault_monitor #(.CNT_WIDTH(4)) dut4 (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .fault00(f4[0]), .fault01(f4[1]), .fault02(f4[2]),
        .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready4),
        .s00_axi_wdata(wdata), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready4),
        .s00_axi_bresp(bresp4), .s00_axi_bvalid(bvalid4), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready4),
        .s00_axi_rdata(rdata4), .s00_axi_rresp(rresp4), .s00_axi_rvalid(rvalid4),
        .s00_axi_rready(rready),
        .recover_req(recover_req4), .recover_ack(ack4), .irq(irq4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write with optional fault pattern applied exactly on the handshake edge
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] hs_fault);
        bit done;
        done = 1'b0;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (awready && wready) begin
                {f2, f1, f0} = hs_fault;
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; {f2, f1, f0} = 3'b000;
        if (!done) check("wr_aw_timeout", 32'd0, 32'd1);
        done = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bvalid) done = 1'b1;
        end
        @(posedge clk); #1;
        bready = 1'b0;
        if (!done) check("wr_b_timeout", 32'd0, 32'd1);
        else check("wr_bresp", 32'(bresp), 32'd0);
    endtask

    // Read; with hold>0 keep rready low and arvalid high, checking rvalid/rdata hold
    task automatic axi_read(input logic [31:0] addr, input int hold, input logic [31:0] hold_exp,
                            output logic [31:0] data);
        bit done;
        done = 1'b0;
        data = 32'hDEAD_BEEF;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (arready) done = 1'b1;
        end
        @(posedge clk); #1;
        if (hold == 0) arvalid = 1'b0;
        if (!done) check("rd_ar_timeout", 32'd0, 32'd1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (rvalid) done = 1'b1;
        end
        if (!done) check("rd_r_timeout", 32'd0, 32'd1);
        data = rdata;
        rdata4_cap = rdata4;
        check("rd_rresp", 32'(rresp), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_rvalid", 32'(rvalid), 32'd1);
            check("hold_rdata", rdata, hold_exp);
            check("hold_no_arready", 32'(arready), 32'd0);
        end
        rready = 1'b1; arvalid = 1'b0;
        @(posedge clk); #1;
        rready = 1'b0;
        if (hold > 0) check("hold_rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    task automatic clear_all();
        axi_write(32'h0, 32'h7, 3'b000);
        axi_write(32'h4, 32'h0, 3'b000);
        axi_write(32'h8, 32'h0, 3'b000);
        axi_write(32'hC, 32'h0, 3'b000);
    endtask

    typedef struct {
        bit          clr;
        logic [2:0]  flt;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_irq;
        logic [2:0]  exp_req;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit          seen;

        tbl[0]  = '{1'b1, 3'b010, 5,  32'h8,  32'h5,  1'b1, 3'b000};
        tbl[1]  = '{1'b0, 3'b000, 1,  32'h0,  32'h2,  1'b1, 3'b000};
        tbl[2]  = '{1'b0, 3'b000, 1,  32'h4,  32'h0,  1'b1, 3'b000};
        tbl[3]  = '{1'b0, 3'b101, 3,  32'h0,  32'h7,  1'b1, 3'b000};
        tbl[4]  = '{1'b0, 3'b000, 1,  32'h4,  32'h3,  1'b1, 3'b000};
        tbl[5]  = '{1'b0, 3'b000, 1,  32'hC,  32'h3,  1'b1, 3'b000};
        tbl[6]  = '{1'b0, 3'b011, 2,  32'h8,  32'h7,  1'b1, 3'b000};
        tbl[7]  = '{1'b0, 3'b000, 1,  32'h4,  32'h5,  1'b1, 3'b000};
        tbl[8]  = '{1'b0, 3'b000, 1,  32'h14, 32'h5,  1'b1, 3'b000};
        tbl[9]  = '{1'b1, 3'b000, 1,  32'h0,  32'h0,  1'b0, 3'b000};
        tbl[10] = '{1'b0, 3'b000, 1,  32'h8,  32'h0,  1'b0, 3'b000};
        tbl[11] = '{1'b0, 3'b100, 15, 32'hC,  32'hF,  1'b1, 3'b000};
        tbl[12] = '{1'b0, 3'b100, 1,  32'hC,  32'h10, 1'b1, 3'b100};
        tbl[13] = '{1'b0, 3'b000, 1,  32'h0,  32'h24, 1'b1, 3'b100};

        rst_n = 1'b0;
        {f2, f1, f0} = 3'b000; f4 = 3'b000;
        awaddr = 32'h0; wdata = 32'h0; araddr = 32'h0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        ack = 3'b000; ack4 = 3'b000; rdata4_cap = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_recover_req", 32'(recover_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven fault patterns and register reads
        for (int v = 0; v < 14; v++) begin
            if (tbl[v].clr) clear_all();
            {f2, f1, f0} = tbl[v].flt;
            repeat (tbl[v].cyc) @(posedge clk);
            #1;
            {f2, f1, f0} = 3'b000;
            axi_read(tbl[v].addr, 0, 32'h0, d);
            check($sformatf("vec%0d_data", v), d, tbl[v].exp_data);
            check($sformatf("vec%0d_irq", v), 32'(irq), 32'(tbl[v].exp_irq));
            check($sformatf("vec%0d_req", v), 32'(recover_req), 32'(tbl[v].exp_req));
        end

        // Ack replica 2 out of REQ: request drops, counter cleared
        ack = 3'b100;
        @(posedge clk); #1;
        ack = 3'b000;
        check("ack2_req", 32'(recover_req), 32'd0);
        axi_read(32'hC, 0, 32'h0, d);
        check("ack2_cnt2", d, 32'd0);

        // Ack while IDLE is ignored
        f1 = 1'b1;
        repeat (2) @(posedge clk);
        #1; f1 = 1'b0;
        ack = 3'b010;
        @(posedge clk); #1;
        ack = 3'b000;
        axi_read(32'h8, 0, 32'h0, d);
        check("idle_ack_cnt1", d, 32'd2);
        check("idle_ack_req", 32'(recover_req), 32'd0);

        // Threshold crossing on replica 0 and acknowledge
        clear_all();
        f0 = 1'b1;
        repeat (16) @(posedge clk);
        #1; f0 = 1'b0;
        check("thr_not_yet", 32'(recover_req), 32'd0);
        @(posedge clk); #1;
        check("thr_req", 32'(recover_req), 32'd1);
        check("thr_irq", 32'(irq), 32'd1);
        ack = 3'b001;
        @(posedge clk); #1;
        ack = 3'b000;
        check("thr_ack_req", 32'(recover_req), 32'd0);
        axi_read(32'h4, 0, 32'h0, d);
        check("thr_ack_cnt0", d, 32'd0);

        // Sticky set beats W1C; counter clear beats increment
        axi_write(32'h0, 32'h7, 3'b001);
        axi_read(32'h0, 0, 32'h0, d);
        check("w1c_vs_set", d, 32'h1);
        axi_write(32'h4, 32'h0, 3'b001);
        axi_read(32'h4, 0, 32'h0, d);
        check("clr_vs_inc", d, 32'h0);

        // Read back-pressure: rready low 3 cycles
        f0 = 1'b1;
        repeat (3) @(posedge clk);
        #1; f0 = 1'b0;
        axi_read(32'h4, 3, 32'h3, d);
        check("bp_data", d, 32'h3);

        // Saturation on the 4-bit-counter instance
        f4 = 3'b100;
        repeat (20) @(posedge clk);
        #1; f4 = 3'b000;
        axi_read(32'hC, 0, 32'h0, d);
        check("sat_cnt2", rdata4_cap, 32'hF);
        check("sat_no_req", 32'(recover_req4), 32'd0);

        // Reset while a write response is pending
        {f2, f1, f0} = 3'b111;
        repeat (3) @(posedge clk);
        #1; {f2, f1, f0} = 3'b000;
        awaddr = 32'h0; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (awready) seen = 1'b1;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bvalid) seen = 1'b1;
        end
        check("rst_mid_bvalid_before", 32'(bvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_bvalid", 32'(bvalid), 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        check("rst_mid_req", 32'(recover_req), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_bresp", 32'(bvalid), 32'd0);
        end
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) begin
            axi_read(32'(r * 4), 0, 32'h0, d);
            check($sformatf("rst_mid_reg%0d", r), d, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tmr_fault_monitor.md
TMR_FAULT_MONITOR -- requirements
Module: tmr_fault_monitor

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: AXI4-Lite data width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32: AXI4-Lite address width; only bits [3:2] decoded.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: per-replica fault counter width.
REQ-004 SHALL have parameter FAULT_THRESHOLD, default 16: counter value that triggers recovery.
REQ-005 SHALL have port axi_aclk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port axi_resetn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports fault00/fault01/fault02, input, 1 each: per-cycle mismatch flags from the TMR voter.
REQ-008 SHALL have AXI4-Lite subordinate ports s00_axi_awaddr/awvalid/awready, wdata/wvalid/wready, bresp[1:0]/bvalid/bready, araddr/arvalid/arready, rdata/rresp[1:0]/rvalid/rready with standard directions and widths.
REQ-009 SHALL have port recover_req, output, 3: per-replica recovery request.
REQ-010 SHALL have port recover_ack, input, 3: per-replica recovery acknowledge.
REQ-011 SHALL have port irq, output, 1: OR of sticky fault bits.

Function
REQ-012 SHALL increment CNTi by 1 each cycle faultNi is high, saturating at all-ones (no wrap).
REQ-013 SHALL set STICKY[i] each cycle faultNi is high; sticky set wins over simultaneous W1C.
REQ-014 SHALL expose registers: 0x0 STATUS {26'b0, recover_req[2:0], STICKY[2:0]}; 0x4 CNT0; 0x8 CNT1; 0xC CNT2, zero-extended.
REQ-015 SHALL treat a write to 0x0 as W1C on STICKY using wdata[2:0]; write to 0x4/0x8/0xC clears that counter; clear wins over simultaneous increment (counter = 0).
REQ-016 SHALL assert awready and wready together for exactly one cycle only when awvalid & wvalid & !bvalid; register update occurs that cycle.
REQ-017 SHALL assert bvalid the cycle after the write handshake, bresp = 2'b00, held until bready.
REQ-018 SHALL assert arready for one cycle when arvalid & !rvalid; rdata captured that cycle; rvalid asserted next cycle, rresp = 2'b00, rdata stable until rready.
REQ-019 SHALL run one recovery FSM per replica: IDLE -> REQ when CNTi >= FAULT_THRESHOLD; REQ -> IDLE when recover_ack[i]=1.
REQ-020 SHALL drive recover_req[i] = 1 exactly while FSM i is in REQ.
REQ-021 SHALL clear CNTi on the REQ -> IDLE transition; recover_ack[i] in IDLE ignored.
REQ-022 SHALL allow all three FSMs to be in REQ simultaneously; no arbitration.
REQ-023 SHALL drive irq = |STICKY, combinationally from registered state.

Reset
REQ-024 SHALL, on axi_resetn low, asynchronously clear counters, STICKY, FSMs (IDLE), recover_req, irq, awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp to 0.
REQ-025 SHALL abandon any in-flight AXI transaction on reset mid-operation; no response issued afterward.

Structure
REQ-026 SHALL place register offsets, FSM state encoding (IDLE, REQ) and OKAY response constant in shared package tmr_pkg.
REQ-027 SHALL implement the per-replica counter + FSM as sub-module tmr_replica_tracker, instantiated three times.

Verification
REQ-028 SHALL cover: fault01 high 5 cycles -> CNT1 reads 5, STATUS reads 0x2, irq=1.
REQ-029 SHALL cover: fault00 high 16 cycles -> recover_req=3'b001 next cycle; ack pulse -> recover_req=0, CNT0 reads 0.
REQ-030 SHALL cover: CNT_WIDTH=4, fault02 high 20 cycles -> CNT2 reads 15 (saturated).
REQ-031 SHALL cover: write 0x0 wdata=0x7 with fault00 high same cycle -> STATUS[2:0]=0x1.
REQ-032 SHALL cover: read 0x4 with rready low 3 cycles -> rvalid held, rdata stable, no second arready.
REQ-033 SHALL cover: reset asserted while bvalid=1 -> bvalid=0 immediately, all registers 0.
